// File: rtl/stack_unit.sv
// Register-file operand stack with synchronous push/pop/peek and a registered top-of-stack output.
// Optional sticky overflow/underflow flags are built when STACK_GUARD_EN is defined.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp_r;
    logic [CW-1:0]    sp_next_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    wr_idx_s;
    logic             do_rep_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic             do_tos_s;
    logic             rd_s;
    logic             ovf_ev_s;
    logic             udf_ev_s;

    // Decode the strobes in priority order and derive the next stack pointer.
    always_comb begin
        top_idx_s = AW'(sp_r - CW'(1));
        wr_idx_s  = AW'(sp_r);
        do_rep_s  = push & pop & ~empty;
        do_push_s = push & ~pop & ~full;
        do_pop_s  = pop & ~push & ~empty;
        do_tos_s  = tos & ~push & ~pop & ~empty;
        rd_s      = do_rep_s | do_pop_s | do_tos_s;
        ovf_ev_s  = push & ~pop & full;
        udf_ev_s  = empty & (pop | (tos & ~push));
        if (do_push_s) begin
            sp_next_s = sp_r + CW'(1);
        end else if (do_pop_s) begin
            sp_next_s = sp_r - CW'(1);
        end else begin
            sp_next_s = sp_r;
        end
    end

    // Stack pointer, status flags and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r    <= {CW{1'b0}};
            d_out   <= {WIDTH{1'b0}};
            d_valid <= 1'b0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            sp_r    <= sp_next_s;
            d_valid <= rd_s;
            empty   <= (sp_next_s == {CW{1'b0}});
            full    <= (sp_next_s == CW'(DEPTH));
            if (rd_s) begin
                d_out <= mem[top_idx_s];
            end else begin
                d_out <= d_out;
            end
        end
    end

    // Storage is not reset; reset only suppresses writes in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_rep_s) begin
                mem[top_idx_s] <= d_in;
            end else if (do_push_s) begin
                mem[wr_idx_s] <= d_in;
            end
        end
    end

    assign count = sp_r;

`ifdef STACK_GUARD_EN
    logic ovf_r;
    logic udf_r;

    // Sticky guard flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | ovf_ev_s;
            udf_r <= udf_r | udf_ev_s;
        end
    end

    assign ovf = ovf_r;
    assign udf = udf_r;
`else
    logic unused_guard_s;
    assign unused_guard_s = ovf_ev_s ^ udf_ev_s;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit (DEPTH=4, WIDTH=8): stimulus queues expected read data,
// a monitor compares it whenever d_valid is seen; status outputs are checked directly.
module tb_stack_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef STACK_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             tos = 1'b0;
    logic [WIDTH-1:0] d_in = 8'h00;
    logic [WIDTH-1:0] d_out;
    logic             d_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] got;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .d_in(d_in),
        .d_out(d_out), .d_valid(d_valid), .count(count), .empty(empty),
        .full(full), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One operation: drive at negedge, let the rising edge act, release after it.
    task automatic op(input logic p, input logic q, input logic t, input logic [7:0] din,
                      input logic expect_rd, input logic [7:0] exp_data);
        @(negedge clk);
        push = p; pop = q; tos = t; d_in = din;
        if (expect_rd) exp_q.push_back(exp_data);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; d_in = 8'h00;
    endtask

    task automatic do_reset(input logic with_pop);
        @(negedge clk);
        rst = 1'b1; pop = with_pop;
        @(posedge clk);
        #1;
        rst = 1'b0; pop = 1'b0;
    endtask

    // Monitor: every d_valid pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (d_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got d_out=0x%0h expected no d_valid", d_out);
                end else begin
                    got = exp_q.pop_front();
                    chk("sb_d_out", int'(d_out), int'(got));
                end
            end
        end
    end

    initial begin
        do_reset(1'b0);
        do_reset(1'b0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_d_valid", int'(d_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_udf", int'(udf), 0);

        op(1, 0, 0, 8'h11, 0, 8'h00);
        op(1, 0, 0, 8'h22, 0, 8'h00);
        op(1, 0, 0, 8'h33, 0, 8'h00);
        chk("push3_count", int'(count), 3);
        op(0, 1, 0, 8'h00, 1, 8'h33);
        chk("pop_count", int'(count), 2);
        chk("pop_d_valid", int'(d_valid), 1);
        op(0, 1, 0, 8'h00, 1, 8'h22);
        op(0, 1, 0, 8'h00, 1, 8'h11);
        chk("drain_empty", int'(empty), 1);

        for (int i = 0; i < 4; i++) op(1, 0, 0, 8'hA0 + 8'(i), 0, 8'h00);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 4);
        op(1, 0, 0, 8'hFF, 0, 8'h00);
        chk("ovf_count", int'(count), 4);
        chk("ovf_flag", int'(ovf), int'(GUARD));
        op(0, 1, 0, 8'h00, 1, 8'hA3);
        chk("after_ovf_full", int'(full), 0);
        op(0, 1, 0, 8'h00, 1, 8'hA2);
        op(0, 1, 0, 8'h00, 1, 8'hA1);
        op(0, 1, 0, 8'h00, 1, 8'hA0);
        chk("drain2_empty", int'(empty), 1);

        op(0, 1, 0, 8'h00, 0, 8'h00);
        chk("udf_d_valid", int'(d_valid), 0);
        chk("udf_d_out", int'(d_out), 8'hA0);
        chk("udf_count", int'(count), 0);
        chk("udf_flag", int'(udf), int'(GUARD));
        op(0, 0, 1, 8'h00, 0, 8'h00);
        chk("tos_empty_d_valid", int'(d_valid), 0);

        op(1, 0, 0, 8'h05, 0, 8'h00);
        op(0, 0, 1, 8'h00, 1, 8'h05);
        op(0, 0, 1, 8'h00, 1, 8'h05);
        chk("tos_count", int'(count), 1);
        chk("tos_d_out", int'(d_out), 8'h05);

        op(1, 1, 0, 8'h09, 1, 8'h05);
        chk("rep_count", int'(count), 1);
        op(0, 1, 0, 8'h00, 1, 8'h09);
        chk("rep_pop_empty", int'(empty), 1);

        op(1, 0, 0, 8'h7E, 0, 8'h00);
        do_reset(1'b1);
        chk("rstpop_count", int'(count), 0);
        chk("rstpop_d_out", int'(d_out), 0);
        chk("rstpop_d_valid", int'(d_valid), 0);
        chk("rstpop_ovf", int'(ovf), 0);
        chk("rstpop_udf", int'(udf), 0);

        op(1, 1, 0, 8'h44, 0, 8'h00);
        chk("rep_empty_count", int'(count), 0);
        chk("rep_empty_d_valid", int'(d_valid), 0);
        chk("rep_empty_udf", int'(udf), int'(GUARD));

        op(1, 0, 0, 8'h5A, 0, 8'h00);
        op(0, 1, 1, 8'h00, 1, 8'h5A);
        chk("poptos_count", int'(count), 0);

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end
endmodule
